// File: rtl/tt_tatzel_spi_cfg.sv
// rtl/tt_tatzel_spi_cfg.sv - SPI mode-0 responder exposing an 8x8 configuration file on the pads
module tt_tatzel_spi_cfg #(
    parameter int SYNC_STAGES = 2,
    parameter int NREGS       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        DONE,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_fall;

    logic [2:0]             cnt;
    logic [7:0]             shreg;
    logic [7:0]             shift_in;
    logic [7:0]             shout;
    logic                   miso_r;
    logic                   wr;
    logic [2:0]             addr;
    logic [7:0]             regs [NREGS];
    logic                   miso;

    // Pad synchronizers; CS_N resets high so nothing looks selected out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ui_in[0]};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], ui_in[1]};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], ui_in[2]};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = cs_prev & ~cs_s;
    assign shift_in  = {shreg[6:0], mosi_s};

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: CS_N high before the 16th rise aborts; ena low parks the block in IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ena && cs_fall) begin
                    state_next = CMD;
                end
            end
            CMD: begin
                if (cs_s) begin
                    state_next = IDLE;
                end else if (sclk_rise && cnt == 3'd7) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (cs_s) begin
                    state_next = IDLE;
                end else if (sclk_rise && cnt == 3'd7) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (cs_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!ena) begin
            state_next = IDLE;
        end
    end

    // Shift datapath, read snapshot at end of CMD, and register file update in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 3'd0;
            shreg  <= 8'h00;
            shout  <= 8'h00;
            miso_r <= 1'b0;
            wr     <= 1'b0;
            addr   <= 3'd0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            case (state)
                IDLE: begin
                    cnt    <= 3'd0;
                    miso_r <= 1'b0;
                end
                CMD: begin
                    if (!cs_s && sclk_rise) begin
                        shreg <= shift_in;
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            wr     <= shreg[6];
                            addr   <= shift_in[2:0];
                            shout  <= regs[shift_in[2:0]];
                            miso_r <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (!cs_s) begin
                        if (sclk_rise) begin
                            shreg <= shift_in;
                            cnt   <= cnt + 3'd1;
                        end
                        if (sclk_fall) begin
                            miso_r <= shout[7];
                            shout  <= {shout[6:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    if (wr && addr != 3'd7) begin
                        regs[addr] <= shreg;
                    end
                    regs[7] <= regs[7] + 8'd1;
                end
                HOLD: begin
                    miso_r <= 1'b0;
                end
                default: begin
                    miso_r <= 1'b0;
                end
            endcase
        end
    end

    assign miso    = (state == DATA) & miso_r;
    assign uo_out  = regs[0];
    assign uio_out = {regs[1][7:1], miso};
    assign uio_oe  = {regs[2][7:1], ~cs_s};

    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in, ui_in[7:3], regs[1][0], regs[2][0]};

endmodule

// File: tb/tb_tt_tatzel_spi_cfg.sv
// tb/tb_tt_tatzel_spi_cfg.sv - directed vector bench for tt_tatzel_spi_cfg
module tb_tt_tatzel_spi_cfg;

    localparam int HALF = 5;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic       sclk;
    logic       cs_n;
    logic       mosi;

    int n_checks;
    int n_fail;

    assign ui_in = {5'b00000, mosi, cs_n, sclk};

    tt_tatzel_spi_cfg #(
        .SYNC_STAGES(2),
        .NREGS(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .ui_in(ui_in),
        .uio_in(uio_in),
        .uo_out(uo_out),
        .uio_out(uio_out),
        .uio_oe(uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] tx;
        logic [7:0]  rx;
        logic [7:0]  uo;
        logic [6:0]  uio_hi;
        logic [6:0]  oe_hi;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        tick(8);
    endtask

    task automatic cs_high();
        tick(HALF);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        tick(HALF);
        m = uio_out[0];
        sclk = 1'b1;
        tick(HALF);
        sclk = 1'b0;
    endtask

    task automatic frame(input logic [15:0] tx, output logic [7:0] rx);
        logic m;
        rx = 8'h00;
        cs_low();
        for (int i = 0; i < 16; i++) begin
            spi_bit(tx[15-i], m);
            if (i >= 8) rx[15-i] = m;
        end
        cs_high();
    endtask

    logic [7:0] rx;
    logic       m;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n  = 1'b0;
        ena    = 1'b1;
        uio_in = 8'h00;
        sclk   = 1'b0;
        cs_n   = 1'b1;
        mosi   = 1'b0;

        vecs[0]  = '{16'h0700, 8'h00, 8'h00, 7'h00, 7'h00};
        vecs[1]  = '{16'h80A5, 8'h00, 8'hA5, 7'h00, 7'h00};
        vecs[2]  = '{16'h0000, 8'hA5, 8'hA5, 7'h00, 7'h00};
        vecs[3]  = '{16'h0700, 8'h03, 8'hA5, 7'h00, 7'h00};
        vecs[4]  = '{16'h81FF, 8'h00, 8'hA5, 7'h7F, 7'h00};
        vecs[5]  = '{16'h820E, 8'h00, 8'hA5, 7'h7F, 7'h07};
        vecs[6]  = '{16'h0100, 8'hFF, 8'hA5, 7'h7F, 7'h07};
        vecs[7]  = '{16'h7A00, 8'h0E, 8'hA5, 7'h7F, 7'h07};
        vecs[8]  = '{16'h0700, 8'h08, 8'hA5, 7'h7F, 7'h07};
        vecs[9]  = '{16'h87FF, 8'h09, 8'hA5, 7'h7F, 7'h07};
        vecs[10] = '{16'h0700, 8'h0A, 8'hA5, 7'h7F, 7'h07};

        tick(4);
        check("reset_uo", {8'h00, uo_out}, 16'h0000);
        check("reset_uio_out", {8'h00, uio_out}, 16'h0000);
        check("reset_uio_oe", {8'h00, uio_oe}, 16'h0000);
        rst_n = 1'b1;
        tick(4);
        check("post_reset_uio_oe", {8'h00, uio_oe}, 16'h0000);

        for (int v = 0; v < 11; v++) begin
            frame(vecs[v].tx, rx);
            check($sformatf("vec%0d_miso", v), {8'h00, rx}, {8'h00, vecs[v].rx});
            check($sformatf("vec%0d_uo", v), {8'h00, uo_out}, {8'h00, vecs[v].uo});
            check($sformatf("vec%0d_uio_hi", v), {9'h000, uio_out[7:1]}, {9'h000, vecs[v].uio_hi});
            check($sformatf("vec%0d_oe_hi", v), {9'h000, uio_oe[7:1]}, {9'h000, vecs[v].oe_hi});
            check($sformatf("vec%0d_oe0_idle", v), {15'h0000, uio_oe[0]}, 16'h0000);
        end

        // Write latency on the 16th rise, plus uio_oe[0] while selected
        cs_low();
        check("oe0_selected", {15'h0000, uio_oe[0]}, 16'h0001);
        for (int i = 0; i < 15; i++) begin
            spi_bit(16'h8033 >> (15 - i) & 16'h1, m);
        end
        mosi = 1'b1;
        tick(HALF);
        sclk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("latency_before", {8'h00, uo_out}, 16'h00A5);
        @(posedge clk);
        #1;
        check("latency_after", {8'h00, uo_out}, 16'h0033);
        tick(HALF);
        sclk = 1'b0;
        check("oe0_selected_end", {15'h0000, uio_oe[0]}, 16'h0001);
        cs_high();

        // Abort after 10 bits of a write to reg3
        cs_low();
        for (int i = 0; i < 10; i++) begin
            spi_bit(16'h833C >> (15 - i) & 16'h1, m);
        end
        cs_high();
        frame(16'h0300, rx);
        check("abort_reg3", {8'h00, rx}, 16'h0000);
        frame(16'h0700, rx);
        check("abort_reg7", {8'h00, rx}, 16'h000D);

        // Frame with ena low is ignored entirely
        ena = 1'b0;
        frame(16'h8077, rx);
        ena = 1'b1;
        check("ena_off_uo", {8'h00, uo_out}, 16'h0033);
        frame(16'h0000, rx);
        check("ena_off_reg0", {8'h00, rx}, 16'h0033);
        frame(16'h0700, rx);
        check("ena_off_reg7", {8'h00, rx}, 16'h000F);

        // 256 completed frames bring the counter back to its pre-burst value
        for (int k = 0; k < 256; k++) begin
            frame(16'h0000, rx);
        end
        frame(16'h0700, rx);
        check("reg7_wrap", {8'h00, rx}, 16'h0010);

        // Reset in the middle of the data phase of a write
        cs_low();
        for (int i = 0; i < 12; i++) begin
            spi_bit(16'h8055 >> (15 - i) & 16'h1, m);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_uo", {8'h00, uo_out}, 16'h0000);
        check("midrst_uio_out", {8'h00, uio_out}, 16'h0000);
        check("midrst_uio_oe", {8'h00, uio_oe}, 16'h0000);
        cs_n = 1'b1;
        sclk = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(4);
        check("postrst_uo", {8'h00, uo_out}, 16'h0000);
        frame(16'h8066, rx);
        check("postrst_write_miso", {8'h00, rx}, 16'h0000);
        check("postrst_write_uo", {8'h00, uo_out}, 16'h0066);
        frame(16'h0700, rx);
        check("postrst_reg7", {8'h00, rx}, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
